// File: rtl/itof_pipe.sv
// itof_pipe: three-stage signed 32-bit integer to IEEE-754 single-precision
// converter with round-to-nearest-even. S1 takes the magnitude, S2 normalises,
// S3 rounds and packs the result that drives y.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is combinational from the stage valids and out_ready, so a
// full pipeline accepts a new request in the same cycle its head is consumed.
// y and out_valid hold steady while out_valid is high and out_ready is low.
module itof_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic        adv1, adv2, adv3;

  logic        v1_q, v1_d;
  logic        s1_q, s1_d;
  logic        z1_q, z1_d;
  logic [31:0] a1_q, a1_d;

  logic        v2_q, v2_d;
  logic        s2_q, s2_d;
  logic        z2_q, z2_d;
  logic [7:0]  e2_q, e2_d;
  logic [30:0] n2_q, n2_d;

  logic        v3_q, v3_d;
  logic [31:0] y3_q, y3_d;

  logic [4:0]  lzc;
  logic [22:0] mant;
  logic        guard, sticky, round_up;
  logic [7:0]  exp_rnd;
  logic [22:0] frac;

  // Stage advance chain: a stage may load whenever it is empty or its
  // downstream neighbour is moving on this edge.
  always_comb begin
    adv3 = !v3_q | out_ready;
    adv2 = !v2_q | adv3;
    adv1 = !v1_q | adv2;
  end

  // S1: capture sign, magnitude and zero flag. 0x80000000 negates to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    z1_d = z1_q;
    a1_d = a1_q;
    if (adv1) begin
      v1_d = in_valid;
      s1_d = x[31];
      z1_d = (x == 32'd0);
      a1_d = x[31] ? (~x + 32'd1) : x;
    end
  end

  // Leading-zero count of the S1 magnitude; the highest set bit wins.
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (a1_q[i]) lzc = 5'(31 - i);
    end
  end

  // S2: normalise so the leading one sits at bit 31. That bit is implicit in
  // the float format, so only the 31 bits below it are kept.
  always_comb begin
    v2_d = v2_q;
    s2_d = s2_q;
    z2_d = z2_q;
    e2_d = e2_q;
    n2_d = n2_q;
    if (adv2) begin
      v2_d = v1_q;
      s2_d = s1_q;
      z2_d = z1_q;
      e2_d = 8'd158 - {3'b000, lzc};
      n2_d = a1_q[30:0] << lzc;
    end
  end

  // Round-to-nearest-even; an all-ones mantissa that rounds up carries into
  // the exponent. The exponent never exceeds 158, so no overflow handling.
  always_comb begin
    mant     = n2_q[30:8];
    guard    = n2_q[7];
    sticky   = |n2_q[6:0];
    round_up = guard & (sticky | mant[0]);
    exp_rnd  = e2_q;
    frac     = mant + {22'd0, round_up};
    if ((&mant) && round_up) begin
      frac    = 23'd0;
      exp_rnd = e2_q + 8'd1;
    end
  end

  // S3: pack the rounded result; zero input yields positive zero.
  always_comb begin
    v3_d = v3_q;
    y3_d = y3_q;
    if (adv3) begin
      v3_d = v2_q;
      y3_d = z2_q ? 32'd0 : {s2_q, exp_rnd, frac};
    end
  end

  // Pipeline registers; reset discards every in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      z1_q <= 1'b0;
      a1_q <= 32'd0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      z2_q <= 1'b0;
      e2_q <= 8'd0;
      n2_q <= 31'd0;
      v3_q <= 1'b0;
      y3_q <= 32'd0;
    end else begin
      v1_q <= v1_d;
      s1_q <= s1_d;
      z1_q <= z1_d;
      a1_q <= a1_d;
      v2_q <= v2_d;
      s2_q <= s2_d;
      z2_q <= z2_d;
      e2_q <= e2_d;
      n2_q <= n2_d;
      v3_q <= v3_d;
      y3_q <= y3_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v3_q;
  assign y         = y3_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed values, backpressure, random traffic and
// mid-stream reset, scored against an arithmetic integer-to-float model.
module tb_itof_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  logic [31:0] exp_q[$];
  int          checks;
  int          errors;
  int          acc_cnt;
  bit          mon_en;
  bit          use_model;

  itof_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact magnitude, then divide down to 24 significant bits and
  // round to nearest, ties to even.
  function automatic logic [31:0] ref_itof(input logic [31:0] xi);
    longint v, mag, q, rem, half;
    int     p, sh;
    logic   sgn;
    v   = longint'($signed(xi));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return 32'd0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {sgn, 8'(p + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = $urandom >> $urandom_range(0, 31);
      2: r = 32'd0 - 32'($urandom_range(0, 1000));
      default: begin
        r = (32'd1 << $urandom_range(24, 30)) + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop on every output transfer, push on every accepted request.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
        else check("y_order", y, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (use_model) exp_q.push_back(ref_itof(x));
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Issue one request on an idle pipeline and measure edges until out_valid.
  task automatic check_latency(input logic [31:0] val, input logic [31:0] expv);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = val;
    @(negedge clk);
    check("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("latency_y", y, expv);
  endtask

  logic [31:0] dx[11];
  logic [31:0] dy[11];
  logic [31:0] bp[8];
  logic [31:0] y_hold;
  int          acc0;
  int          cyc;

  initial begin
    checks = 0; errors = 0; acc_cnt = 0;
    mon_en = 1'b0; use_model = 1'b1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 32'd0;

    // Reset state, while held and after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    check_latency(32'h0000_0001, 32'h3F80_0000);
    drain("drain_first");

    // Directed values, one per cycle, expectations from the table
    dx[0]  = 32'h0000_0000; dy[0]  = 32'h0000_0000;
    dx[1]  = 32'h0000_0001; dy[1]  = 32'h3F80_0000;
    dx[2]  = 32'hFFFF_FFFF; dy[2]  = 32'hBF80_0000;
    dx[3]  = 32'h0000_000A; dy[3]  = 32'h4120_0000;
    dx[4]  = 32'h7FFF_FFFF; dy[4]  = 32'h4F00_0000;
    dx[5]  = 32'h8000_0000; dy[5]  = 32'hCF00_0000;
    dx[6]  = 32'h7FFF_FFC0; dy[6]  = 32'h4F00_0000;
    dx[7]  = 32'h0100_0001; dy[7]  = 32'h4B80_0000;
    dx[8]  = 32'h0100_0003; dy[8]  = 32'h4B80_0002;
    dx[9]  = 32'h0100_0005; dy[9]  = 32'h4B80_0002;
    dx[10] = 32'hFEFF_FFFD; dy[10] = 32'hCB80_0002;
    use_model = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      x = dx[i];
      exp_q.push_back(dy[i]);
      @(negedge clk);
      check("dir_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    drain("drain_directed");
    use_model = 1'b1;

    // Backpressure: fill with out_ready low, then release
    for (int i = 0; i < 8; i++) bp[i] = $urandom;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    in_valid = 1'b1;
    x = bp[0];
    repeat (6) begin
      @(posedge clk); #1;
      if (acc_cnt - acc0 < 8) x = bp[acc_cnt - acc0];
    end
    check("bp_accepted", 32'(acc_cnt - acc0), 32'd3);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", y, ref_itof(bp[0]));
    y_hold = y;
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_y_stable", y, y_hold);
      check("bp_valid_stable", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_push_pop_ready", {31'd0, in_ready}, 32'd1);
    cyc = 0;
    while (acc_cnt - acc0 < 8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_cnt - acc0 < 8) x = bp[acc_cnt - acc0];
    end
    check("bp_total", 32'(acc_cnt - acc0), 32'd8);
    drain("drain_bp");

    // Random traffic
    acc0 = acc_cnt;
    cyc = 0;
    while (acc_cnt - acc0 < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      x = rand_x();
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_accepted", 32'(acc_cnt - acc0), 32'd10000);
    drain("drain_rand");

    // Reset with all three stages full
    out_ready = 1'b0;
    acc0 = acc_cnt;
    in_valid = 1'b1;
    x = rand_x();
    cyc = 0;
    while (acc_cnt - acc0 < 3 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      x = rand_x();
    end
    check("rst_fill", 32'(acc_cnt - acc0), 32'd3);
    check("rst_full_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", y, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_idle", {31'd0, out_valid}, 32'd0);
    check_latency(32'd2, 32'h4000_0000);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
